// File: rtl/rle_block_assembler.sv
// ---------------------------------------------------------------------------
// rle_block_assembler
//
// Expands run-length coded JPEG coefficient symbols into 64-entry blocks held
// in zigzag order. Each completed block is presented as one flat vector to the
// downstream inverse-zigzag row selector.
//
// There are two banks. One bank is filled from the symbol stream while the
// other is held for the consumer. A bank is cleared when it is released, so
// coefficients that no symbol writes are already zero. The block never spends
// cycles writing zeros.
//
// Ports
//   clk, rst_n    clock; asynchronous active-low reset
//   sym_valid     a symbol is present
//   sym_ready     a symbol can be accepted this cycle (the filling bank is not full)
//   sym_run       number of zero coefficients that precede sym_value
//   sym_value     coefficient value
//   sym_eob       end of block; sym_run and sym_value are ignored when set
//   blk_data      completed block; zigzag index k is at
//                 [DATA_W*(64-k)-1 -: DATA_W]; all zeros when no block is held
//   blk_valid     blk_data holds a completed block
//   blk_ready     the consumer releases the presented block
//   err_overrun   one-cycle pulse after a symbol that addressed beyond index 63
// ---------------------------------------------------------------------------
module rle_block_assembler #(
  parameter int DATA_W = 8,
  parameter int RUN_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  input  logic [RUN_W-1:0]     sym_run,
  input  logic [DATA_W-1:0]    sym_value,
  input  logic                 sym_eob,
  output logic [64*DATA_W-1:0] blk_data,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic                 err_overrun
);

  localparam int DEPTH = 64;
  // The target index is wide enough to hold pos (up to 64) plus the largest run
  // without wrapping, so an overrun is always detected.
  localparam int TGT_W = ((RUN_W > 7) ? RUN_W : 7) + 1;

  logic [DATA_W-1:0] bank [2][DEPTH];
  logic [1:0]        full;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [6:0]        pos;
  logic              err_q;

  logic              accept;
  logic              release_blk;
  logic [TGT_W-1:0]  target;
  logic              in_range;
  logic              complete;

  // The handshake outputs depend only on registered state.
  // sym_ready never depends on sym_valid.
  assign sym_ready   = ~full[wr_ptr];
  assign blk_valid   = full[rd_ptr];
  assign err_overrun = err_q;

  // NOTE: every signal assigned in always_comb receives a default first. This
  // keeps the block free of inferred latches.
  always_comb begin
    accept      = sym_valid & sym_ready;
    release_blk = blk_valid & blk_ready;
    target      = TGT_W'(pos) + TGT_W'(sym_run);
    in_range    = (target <= TGT_W'(DEPTH - 1));
    // The bank completes on EOB, when the last index is written, or when a
    // symbol addresses beyond index 63. On overrun the current contents are
    // emitted as they are.
    complete    = accept & (sym_eob | (target >= TGT_W'(DEPTH - 1)));
  end

  always_comb begin
    blk_data = '0;
    if (blk_valid) begin
      for (int k = 0; k < DEPTH; k++) begin
        blk_data[DATA_W*(DEPTH-k)-1 -: DATA_W] = bank[rd_ptr][k];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // therefore samples the values from before the edge, and the order of
  // statements below cannot change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the banks are reset explicitly. A partially filled block must be
      // discarded, and the zero-fill scheme relies on every bank starting at zero.
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < DEPTH; k++) begin
          bank[b][k] <= '0;
        end
      end
      full   <= 2'b00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      pos    <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept & ~sym_eob & ~in_range;

      // A release clears the bank it frees. A release and a completion in the
      // same cycle touch different banks, because the filling bank is never full.
      if (release_blk) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
          bank[rd_ptr][k] <= '0;
        end
      end

      if (accept & ~sym_eob & in_range) begin
        bank[wr_ptr][target[5:0]] <= sym_value;
      end

      if (accept) begin
        if (complete) begin
          full[wr_ptr] <= 1'b1;
          wr_ptr       <= ~wr_ptr;
          pos          <= '0;
        end else begin
          pos <= target[6:0] + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rle_block_assembler.sv
// ---------------------------------------------------------------------------
// tb_rle_block_assembler
//
// Directed bench for rle_block_assembler.
// - A per-cycle vector table covers the handshake: the basic block, EOB as the
//   first symbol, back-pressure with two full banks, and the release ordering.
// - Hand-written sequences cover the long fills: a 64-symbol block, an exact
//   hit on index 63, an overrun at pos 60, and a reset in the middle of a fill.
// ---------------------------------------------------------------------------
module tb_rle_block_assembler;

  localparam int DATA_W = 8;
  localparam int RUN_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sym_valid;
  logic              sym_ready;
  logic [RUN_W-1:0]  sym_run;
  logic [DATA_W-1:0] sym_value;
  logic              sym_eob;
  logic [511:0]      blk_data;
  logic              blk_valid;
  logic              blk_ready;
  logic              err_overrun;

  int total = 0;
  int bad   = 0;

  rle_block_assembler #(.DATA_W(DATA_W), .RUN_W(RUN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_run     (sym_run),
    .sym_value   (sym_value),
    .sym_eob     (sym_eob),
    .blk_data    (blk_data),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       eob;
    logic [5:0] run;
    logic [7:0] val;
    logic       rdy;
    logic       e_srdy;
    logic       e_bval;
    logic       e_err;
    logic [7:0] e_b0;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic v, logic eob, logic [5:0] run, logic [7:0] val,
                              logic rdy, logic e_srdy, logic e_bval, logic e_err,
                              logic [7:0] e_b0);
    vec_t r;
    r.v = v; r.eob = eob; r.run = run; r.val = val; r.rdy = rdy;
    r.e_srdy = e_srdy; r.e_bval = e_bval; r.e_err = e_err; r.e_b0 = e_b0;
    return r;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int k);
    return blk_data[8*(64-k)-1 -: 8];
  endfunction

  // Presents one symbol and waits, for a bounded number of cycles, until it is
  // accepted. Returns #1 after the accepting edge.
  task automatic send(input logic eob, input logic [5:0] run, input logic [7:0] val);
    int n = 0;
    sym_valid = 1'b1; sym_eob = eob; sym_run = run; sym_value = val;
    while (!sym_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n == 20) check("send_timeout", 512'd1, 512'd0);
    @(posedge clk); #1;
    sym_valid = 1'b0; sym_eob = 1'b0; sym_run = '0; sym_value = '0;
  endtask

  task automatic release_blk();
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] exp;

    rst_n = 1'b0; sym_valid = 1'b0; sym_eob = 1'b0; sym_run = '0;
    sym_value = '0; blk_ready = 1'b0;
    #12;
    check("rst_sym_ready", 512'(sym_ready), 512'd1);
    check("rst_blk_valid", 512'(blk_valid), 512'd0);
    check("rst_err", 512'(err_overrun), 512'd0);
    check("rst_blk_data", blk_data, 512'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Each row lasts one cycle. Expected outputs are sampled #1 after the edge.
    //            v    eob  run   val    rdy  srdy bval err  b0
    tbl[0]  = mk(1'b1, 1'b0, 6'd0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tbl[1]  = mk(1'b1, 1'b0, 6'd2, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tbl[2]  = mk(1'b1, 1'b1, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11);
    tbl[3]  = mk(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    tbl[4]  = mk(1'b1, 1'b1, 6'd9, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tbl[5]  = mk(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    tbl[6]  = mk(1'b1, 1'b0, 6'd0, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tbl[7]  = mk(1'b1, 1'b1, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA1);
    tbl[8]  = mk(1'b1, 1'b0, 6'd0, 8'hB2, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA1);
    tbl[9]  = mk(1'b1, 1'b1, 6'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA1);
    tbl[10] = mk(1'b1, 1'b0, 6'd0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA1);
    tbl[11] = mk(1'b1, 1'b0, 6'd0, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 8'hB2);
    tbl[12] = mk(1'b1, 1'b0, 6'd0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 8'hB2);
    tbl[13] = mk(1'b1, 1'b1, 6'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB2);
    tbl[14] = mk(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC3);
    tbl[15] = mk(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    tbl[16] = mk(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 17; i++) begin
      sym_valid = tbl[i].v; sym_eob = tbl[i].eob; sym_run = tbl[i].run;
      sym_value = tbl[i].val; blk_ready = tbl[i].rdy;
      @(posedge clk); #1;
      check($sformatf("vec%0d_sym_ready", i), 512'(sym_ready), 512'(tbl[i].e_srdy));
      check($sformatf("vec%0d_blk_valid", i), 512'(blk_valid), 512'(tbl[i].e_bval));
      check($sformatf("vec%0d_err", i), 512'(err_overrun), 512'(tbl[i].e_err));
      check($sformatf("vec%0d_byte0", i), 512'(byte_at(0)), 512'(tbl[i].e_b0));
      if (i == 2) begin
        // Full-block check for the first basic block.
        exp = '0;
        exp[8*64-1 -: 8] = 8'h11;
        exp[8*61-1 -: 8] = 8'h22;
        check("vec2_block", blk_data, exp);
      end
    end
    sym_valid = 1'b0; sym_eob = 1'b0; blk_ready = 1'b0;

    // 64 symbols with run=0 complete the block on the last one.
    for (int k = 0; k < 63; k++) send(1'b0, 6'd0, 8'(k));
    check("fill63_not_valid", 512'(blk_valid), 512'd0);
    send(1'b0, 6'd0, 8'd63);
    check("fill64_valid", 512'(blk_valid), 512'd1);
    check("fill64_sym_ready", 512'(sym_ready), 512'd1);
    exp = '0;
    for (int k = 0; k < 64; k++) exp[8*(64-k)-1 -: 8] = 8'(k);
    check("fill64_block", blk_data, exp);
    // The next block starts again at index 0 in the other bank.
    send(1'b0, 6'd0, 8'h55);
    send(1'b1, 6'd0, 8'h00);
    check("fill64_held", blk_data, exp);
    release_blk();
    exp = '0;
    exp[8*64-1 -: 8] = 8'h55;
    check("pos_restart_block", blk_data, exp);
    release_blk();
    check("drained", 512'(blk_valid), 512'd0);

    // A symbol that lands exactly on index 63 writes it and completes the block.
    send(1'b0, 6'd63, 8'h77);
    check("idx63_valid", 512'(blk_valid), 512'd1);
    check("idx63_err", 512'(err_overrun), 512'd0);
    exp = '0;
    exp[7:0] = 8'h77;
    check("idx63_block", blk_data, exp);
    release_blk();

    // Overrun: pos=60 with run=5 targets index 65.
    for (int k = 0; k < 60; k++) send(1'b0, 6'd0, 8'(k + 1));
    check("ovr_pre_valid", 512'(blk_valid), 512'd0);
    send(1'b0, 6'd5, 8'hEE);
    check("ovr_err_pulse", 512'(err_overrun), 512'd1);
    check("ovr_valid", 512'(blk_valid), 512'd1);
    exp = '0;
    for (int k = 0; k < 60; k++) exp[8*(64-k)-1 -: 8] = 8'(k + 1);
    check("ovr_block", blk_data, exp);
    @(posedge clk); #1;
    check("ovr_err_cleared", 512'(err_overrun), 512'd0);
    release_blk();

    // Reset in the middle of a fill while another block is pending.
    send(1'b0, 6'd0, 8'h42);
    send(1'b1, 6'd0, 8'h00);
    for (int k = 0; k < 20; k++) send(1'b0, 6'd0, 8'(k + 100));
    check("midrst_pre_valid", 512'(blk_valid), 512'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 512'(blk_valid), 512'd0);
    check("midrst_sym_ready", 512'(sym_ready), 512'd1);
    check("midrst_data", blk_data, 512'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(1'b1, 6'd0, 8'h00);
    check("post_rst_valid", 512'(blk_valid), 512'd1);
    check("post_rst_block", blk_data, 512'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
